// File: rtl/r4_pkg.sv
// Shared types and constants for the instruction-memory loader and its UART receiver.
package r4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RUN,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  LOADER_MAGIC = 8'hA5;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: start confirmed at half-bit, data and stop sampled at bit centres.
module uart_rx
  import r4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t       r_state, w_next;
  logic            r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_valid;
  logic            w_tick;

  assign w_tick   = (r_state == RX_START) ? (r_baud == HALF) : (r_baud == FULL);
  assign rx_data  = r_shift;
  assign rx_valid = r_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (r_rx_s3 && !r_rx_s2) w_next = RX_START;
      RX_START: if (w_tick) w_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_bit == 3'd7) w_next = RX_STOP;
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= RX_IDLE;
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      r_state <= w_next;
      r_valid <= 1'b0;
      if (r_state == RX_IDLE || w_tick) r_baud <= '0;
      else r_baud <= r_baud + 1'b1;
      if (r_state == RX_IDLE) r_bit <= '0;
      if (r_state == RX_DATA && w_tick) begin
        r_shift <= {r_rx_s2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      // A low stop bit drops the byte silently.
      if (r_state == RX_STOP && w_tick && r_rx_s2) r_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a UART program frame into instruction RAM, holds the cpu in reset until it verifies.
//   state | meaning
//   IDLE  | waiting for magic byte
//   LEN0  | expecting word count low byte
//   LEN1  | expecting word count high byte
//   DATA  | collecting little-endian payload words
//   CSUM  | expecting payload checksum
//   RUN   | image valid, cpu released
//   ERROR | bad length, checksum or timeout
module imem_loader
  import r4_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        rx,
  input  logic [31:0] instrAddr,
  output logic [31:0] instr,
  output logic        cpu_n_reset,
  output logic        loaded,
  output logic        err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t  r_state, w_next;
  logic [15:0]    r_len;
  logic [15:0]    r_word_idx;
  logic [1:0]     r_byte;
  logic [23:0]    r_word;
  logic [7:0]     r_sum;
  logic [TCW-1:0] r_tcnt;
  logic           r_cpu_n_reset, r_loaded, r_err;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic [7:0]     w_rx_data;
  logic           w_rx_valid;
  logic           w_wr;
  logic           w_timed;
  logic [15:0]    w_len;
  logic           w_unused_addr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk      (clk),
    .n_reset  (n_reset),
    .rx       (rx),
    .rx_data  (w_rx_data),
    .rx_valid (w_rx_valid)
  );

  assign w_len   = {w_rx_data, r_len[7:0]};
  assign w_timed = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA) || (r_state == CSUM);

  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    case (r_state)
      IDLE: if (w_rx_valid && w_rx_data == LOADER_MAGIC) w_next = LEN0;
      LEN0: if (w_rx_valid) w_next = LEN1;
      LEN1: if (w_rx_valid) begin
        if ({1'b0, w_len} > 17'(DEPTH_WORDS)) w_next = ERROR;
        else if (w_len == 16'd0)              w_next = CSUM;
        else                                  w_next = DATA;
      end
      DATA: if (w_rx_valid && r_byte == 2'd3) begin
        w_wr = n_reset;
        if (r_word_idx == r_len - 16'd1) w_next = CSUM;
      end
      CSUM: if (w_rx_valid) w_next = (w_rx_data == r_sum) ? RUN : ERROR;
      RUN, ERROR: if (w_rx_valid && w_rx_data == LOADER_MAGIC) w_next = LEN0;
      default: w_next = IDLE;
    endcase
    if (w_timed && !w_rx_valid && r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) w_next = ERROR;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_word_idx    <= '0;
      r_byte        <= '0;
      r_word        <= '0;
      r_sum         <= '0;
      r_tcnt        <= '0;
      r_cpu_n_reset <= 1'b0;
      r_loaded      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cpu_n_reset <= (w_next == RUN);
      r_loaded      <= (w_next == RUN);
      r_err         <= (w_next == ERROR);
      if (!w_timed || w_rx_valid || w_next != r_state) r_tcnt <= '0;
      else r_tcnt <= r_tcnt + 1'b1;
      if (w_next == LEN0 && r_state != LEN0) begin
        r_word_idx <= '0;
        r_byte     <= '0;
        r_sum      <= '0;
      end else if (w_rx_valid) begin
        case (r_state)
          LEN0: r_len[7:0]  <= w_rx_data;
          LEN1: r_len[15:8] <= w_rx_data;
          DATA: begin
            r_byte <= r_byte + 2'd1;
            r_sum  <= r_sum + w_rx_data;
            case (r_byte)
              2'd0:    r_word[7:0]   <= w_rx_data;
              2'd1:    r_word[15:8]  <= w_rx_data;
              2'd2:    r_word[23:16] <= w_rx_data;
              default: r_word_idx    <= r_word_idx + 16'd1;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // RAM is deliberately not reset so a reset mid-frame keeps already written words.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_word_idx[AW-1:0]] <= {w_rx_data, r_word};
  end

  assign w_unused_addr = ^instrAddr[1:0];
  assign instr = (r_state == RUN && instrAddr[31:AW+2] == '0) ? r_mem[instrAddr[AW+1:2]] : NOP_INSTR;

  assign cpu_n_reset = r_cpu_n_reset;
  assign loaded      = r_loaded;
  assign err         = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with a word-array reference model.
module tb_imem_loader;

  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int TO    = 50;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] instrAddr = '0;
  logic [31:0] instr;
  logic        cpu_n_reset, loaded, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  bit          m_run = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(DEPTH), .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rx          (rx),
    .instrAddr   (instrAddr),
    .instr       (instr),
    .cpu_n_reset (cpu_n_reset),
    .loaded      (loaded),
    .err         (err)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    int unsigned idx;
    idx = a / 4;
    if (!m_run || idx >= DEPTH) return NOP;
    return m_mem[idx];
  endfunction

  function automatic logic flag(input int which);
    case (which)
      0:       return loaded;
      1:       return err;
      default: return cpu_n_reset;
    endcase
  endfunction

  task automatic wait_flag(input int which, input logic val, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (flag(which) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = !bad_stop;
    repeat (CPB - 1) @(negedge clk);
    if (bad_stop) begin
      @(negedge clk) rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] words[$], input int n, input bit bad_csum);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    m_run = 1'b0;
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        s = s + b;
        send_byte(b);
      end
      m_mem[i]     = words[i];
      m_written[i] = 1'b1;
    end
    send_byte(bad_csum ? s + 8'd1 : s);
    m_run = !bad_csum;
  endtask

  task automatic read_instr(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk) instrAddr = a;
    #1 d = instr;
  endtask

  task automatic pulse_reset();
    @(negedge clk) n_reset = 1'b0;
    @(negedge clk) n_reset = 1'b1;
    m_run = 1'b0;
  endtask

  task automatic random_reads(input string name, input int count);
    logic [31:0] a, d;
    int idx;
    for (int i = 0; i < count; i++) begin
      idx = $urandom_range(0, DEPTH - 1);
      if (!m_written[idx]) continue;
      a = 32'(idx * 4) + 32'($urandom_range(0, 3));
      read_instr(a, d);
      n_tests++;
      if (d !== model_instr(a)) begin
        n_fail++;
        $display("FAIL %s addr=%h got=%h exp=%h", name, a, d, model_instr(a));
      end
    end
    a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
    read_instr(a, d);
    n_tests++;
    if (d !== NOP) begin
      n_fail++;
      $display("FAIL %s_oob addr=%h got=%h exp=%h", name, a, d, NOP);
    end
  endtask

  task automatic check_status(input string name);
    bit ok;
    logic [2:0] got, exp;
    wait_flag(m_run ? 0 : 1, 1'b1, 16, ok);
    got = {cpu_n_reset, loaded, err};
    exp = {m_run, m_run, !m_run};
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL %s status {cpu_n_reset,loaded,err} got=%b exp=%b settled=%0d", name, got, exp, ok);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    m_run = 1'b0;
    read_instr(32'h0, d);
    n_tests++;
    if ({cpu_n_reset, loaded, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=000", {cpu_n_reset, loaded, err});
    end
    n_tests++;
    if (d !== NOP) begin
      n_fail++;
      $display("FAIL reset_instr got=%h exp=%h", d, NOP);
    end
  endtask

  task automatic test_load();
    logic [31:0] w[$];
    logic [31:0] d;
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h6};
    logic [31:0] exps  [3] = '{32'h0FF00093, 32'h00108133, 32'h00108133};
    w = '{32'h0FF00093, 32'h00108133};
    send_frame(w, 2, 1'b0);
    check_status("load");
    for (int i = 0; i < 3; i++) begin
      read_instr(addrs[i], d);
      n_tests++;
      if (d !== exps[i]) begin
        n_fail++;
        $display("FAIL load_read addr=%h got=%h exp=%h", addrs[i], d, exps[i]);
      end
    end
    random_reads("load_rand", 2);
  endtask

  task automatic test_bad_csum();
    logic [31:0] w[$];
    logic [31:0] d;
    w = '{32'h0FF00093, 32'h00108133};
    send_frame(w, 2, 1'b1);
    check_status("bad_csum");
    read_instr(32'h0, d);
    n_tests++;
    if (d !== NOP) begin
      n_fail++;
      $display("FAIL bad_csum_instr got=%h exp=%h", d, NOP);
    end
    w = {};
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    send_frame(w, 3, 1'b0);
    check_status("recover");
    random_reads("recover_rand", 6);
  endtask

  task automatic test_len_bounds();
    logic [31:0] w[$];
    logic [31:0] d;
    logic [31:0] a;
    w = {};
    send_frame(w, DEPTH + 1, 1'b0);
    check_status("len_over");
    send_frame(w, 0, 1'b0);
    check_status("len_zero");
    random_reads("ram_unchanged", 8);
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    send_frame(w, DEPTH, 1'b0);
    check_status("len_full");
    a = 32'(4 * (DEPTH - 1));
    read_instr(a, d);
    n_tests++;
    if (d !== w[DEPTH-1]) begin
      n_fail++;
      $display("FAIL len_full_last addr=%h got=%h exp=%h", a, d, w[DEPTH-1]);
    end
    random_reads("len_full_rand", 8);
  endtask

  task automatic test_timeout();
    bit ok;
    pulse_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (30) @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early err got=%b exp=0", err);
    end
    wait_flag(1, 1'b1, 60, ok);
    n_tests++;
    if (!ok || cpu_n_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err got err=%b cpu_n_reset=%b exp err=1 cpu_n_reset=0", err, cpu_n_reset);
    end
    pulse_reset();
    send_byte(8'h3C);
    repeat (2 * TO) @(negedge clk);
    n_tests++;
    if ({cpu_n_reset, loaded, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL stray_byte got=%b exp=000", {cpu_n_reset, loaded, err});
    end
  endtask

  task automatic test_reload_reset();
    logic [31:0] w[$];
    logic [31:0] d;
    bit ok;
    for (int i = 0; i < 2; i++) w.push_back($urandom);
    send_frame(w, 2, 1'b0);
    check_status("pre_reload");
    send_byte(8'hA5);
    wait_flag(2, 1'b0, 8, ok);
    n_tests++;
    if (!ok || loaded !== 1'b0) begin
      n_fail++;
      $display("FAIL reload got cpu_n_reset=%b loaded=%b exp 0 0", cpu_n_reset, loaded);
    end
    m_run = 1'b0;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hDE);
    send_byte(8'hAD);
    pulse_reset();
    read_instr(32'h0, d);
    n_tests++;
    if ({cpu_n_reset, loaded, err} !== 3'b000 || d !== NOP) begin
      n_fail++;
      $display("FAIL mid_reset got=%b instr=%h exp=000 instr=%h", {cpu_n_reset, loaded, err}, d, NOP);
    end
    repeat (2 * TO) @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle err got=%b exp=0", err);
    end
    w = {};
    for (int i = 0; i < 2; i++) w.push_back($urandom);
    send_frame(w, 2, 1'b0);
    check_status("post_reset_load");
    send_byte(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    n_tests++;
    if ({cpu_n_reset, loaded, err} !== 3'b110) begin
      n_fail++;
      $display("FAIL bad_stop got=%b exp=110", {cpu_n_reset, loaded, err});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    int n;
    bit bad;
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      send_frame(w, n, bad);
      check_status("b2b");
      random_reads("b2b_rand", 4);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_csum();
    test_len_bounds();
    test_timeout();
    test_reload_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
